// File: rtl/axi_tagctrl_tag_arb.sv
// Tag-cache lookup port arbiter: round-robins read/write tag requests onto one
// registered tag-cache request stage and routes in-order responses back.
module axi_tagctrl_tag_arb #(
    parameter int unsigned           AddrWidth       = 64,
    parameter int unsigned           IdWidth         = 4,
    parameter int unsigned           CapSize         = 128,
    parameter logic [AddrWidth-1:0]  DRAMMemBase     = 'h8000_0000,
    parameter logic [AddrWidth-1:0]  DRAMMemLength   = 'h4000_0000,
    parameter logic [AddrWidth-1:0]  TagCacheMemBase = 'hBE00_0000,
    parameter int unsigned           MaxOutstanding  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 rd_req_valid_i,
    output logic                 rd_req_ready_o,
    input  logic [AddrWidth-1:0] rd_req_addr_i,
    input  logic [IdWidth-1:0]   rd_req_id_i,

    input  logic                 wr_req_valid_i,
    output logic                 wr_req_ready_o,
    input  logic [AddrWidth-1:0] wr_req_addr_i,
    input  logic [IdWidth-1:0]   wr_req_id_i,
    input  logic                 wr_req_tag_i,

    output logic                 tc_req_valid_o,
    input  logic                 tc_req_ready_i,
    output logic [AddrWidth-1:0] tc_req_addr_o,
    output logic [2:0]           tc_req_bit_o,
    output logic                 tc_req_we_o,
    output logic                 tc_req_wtag_o,

    input  logic                 tc_rsp_valid_i,
    output logic                 tc_rsp_ready_o,
    input  logic                 tc_rsp_tag_i,

    output logic                 rd_rsp_valid_o,
    input  logic                 rd_rsp_ready_i,
    output logic [IdWidth-1:0]   rd_rsp_id_o,
    output logic                 rd_rsp_tag_o,
    output logic                 rd_rsp_err_o,

    output logic                 wr_rsp_valid_o,
    input  logic                 wr_rsp_ready_i,
    output logic [IdWidth-1:0]   wr_rsp_id_o,
    output logic                 wr_rsp_err_o
);

    localparam int unsigned CapShift = $clog2(CapSize / 8);
    localparam int unsigned PtrW     = $clog2(MaxOutstanding);
    localparam int unsigned CntW     = PtrW + 1;
    localparam int unsigned EntW     = IdWidth + 2;

    logic                 ptr_q, ptr_d;
    logic                 tc_valid_q, tc_valid_d;
    logic [AddrWidth-1:0] tc_addr_q, tc_addr_d;
    logic [2:0]           tc_bit_q, tc_bit_d;
    logic                 tc_we_q, tc_we_d;
    logic                 tc_wtag_q, tc_wtag_d;

    // Tracking entry layout: {src (1 = write path), id, err}
    logic [EntW-1:0]      fifo_q [MaxOutstanding];
    logic [EntW-1:0]      fifo_d [MaxOutstanding];
    logic [PtrW-1:0]      head_q, head_d;
    logic [PtrW-1:0]      tail_q, tail_d;
    logic [CntW-1:0]      cnt_q, cnt_d;

    logic                 fifo_full, fifo_empty;
    logic                 can_grant, gnt_rd, gnt_wr, gnt;
    logic [AddrWidth-1:0] sel_addr, off, cap_idx;
    logic [IdWidth-1:0]   sel_id;
    logic [AddrWidth:0]   win_end;
    logic                 out_of_range;

    logic [EntW-1:0]      head_ent;
    logic                 head_src, head_err;
    logic [IdWidth-1:0]   head_id;
    logic                 pop;

    logic                 rd_rsp_valid, wr_rsp_valid, rd_rsp_tag, rd_rsp_err, wr_rsp_err;
    logic [IdWidth-1:0]   rd_rsp_id, wr_rsp_id;
    logic                 tc_rsp_ready;

    assign fifo_full  = (cnt_q == CntW'(MaxOutstanding));
    assign fifo_empty = (cnt_q == '0);

    // A same-cycle pop does not free a slot for a grant.
    assign can_grant = !fifo_full && (!tc_valid_q || tc_req_ready_i) && !rst_i;
    assign gnt_rd    = can_grant && rd_req_valid_i && (!ptr_q || !wr_req_valid_i);
    assign gnt_wr    = can_grant && wr_req_valid_i && (ptr_q || !rd_req_valid_i);
    assign gnt       = gnt_rd || gnt_wr;

    assign sel_addr     = gnt_wr ? wr_req_addr_i : rd_req_addr_i;
    assign sel_id       = gnt_wr ? wr_req_id_i : rd_req_id_i;
    assign off          = sel_addr - DRAMMemBase;
    assign cap_idx      = off >> CapShift;
    assign win_end      = {1'b0, DRAMMemBase} + {1'b0, DRAMMemLength};
    assign out_of_range = (sel_addr < DRAMMemBase) || ({1'b0, sel_addr} >= win_end);

    assign head_ent = fifo_q[head_q];
    assign head_src = head_ent[EntW-1];
    assign head_id  = head_ent[IdWidth:1];
    assign head_err = head_ent[0];

    always_comb begin
        rd_rsp_valid = 1'b0;
        rd_rsp_id    = '0;
        rd_rsp_tag   = 1'b0;
        rd_rsp_err   = 1'b0;
        wr_rsp_valid = 1'b0;
        wr_rsp_id    = '0;
        wr_rsp_err   = 1'b0;
        tc_rsp_ready = 1'b0;
        pop          = 1'b0;
        if (!fifo_empty) begin
            if (head_err) begin
                // Error entries answer locally; the tag cache never saw them.
                if (head_src) begin
                    wr_rsp_valid = 1'b1;
                    wr_rsp_id    = head_id;
                    wr_rsp_err   = 1'b1;
                    pop          = wr_rsp_ready_i;
                end else begin
                    rd_rsp_valid = 1'b1;
                    rd_rsp_id    = head_id;
                    rd_rsp_err   = 1'b1;
                    pop          = rd_rsp_ready_i;
                end
            end else begin
                if (head_src) begin
                    wr_rsp_valid = tc_rsp_valid_i;
                    wr_rsp_id    = head_id;
                    tc_rsp_ready = wr_rsp_ready_i;
                end else begin
                    rd_rsp_valid = tc_rsp_valid_i;
                    rd_rsp_id    = head_id;
                    rd_rsp_tag   = tc_rsp_tag_i;
                    tc_rsp_ready = rd_rsp_ready_i;
                end
                pop = tc_rsp_valid_i && tc_rsp_ready;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt && rd_req_valid_i && wr_req_valid_i) begin
            ptr_d = ~ptr_q;
        end

        tc_valid_d = tc_valid_q;
        tc_addr_d  = tc_addr_q;
        tc_bit_d   = tc_bit_q;
        tc_we_d    = tc_we_q;
        tc_wtag_d  = tc_wtag_q;
        if (tc_req_ready_i) begin
            tc_valid_d = 1'b0;
        end
        if (gnt && !out_of_range) begin
            tc_valid_d = 1'b1;
            tc_addr_d  = TagCacheMemBase + (cap_idx >> 3);
            tc_bit_d   = cap_idx[2:0];
            tc_we_d    = gnt_wr;
            tc_wtag_d  = gnt_wr && wr_req_tag_i;
        end

        fifo_d = fifo_q;
        if (gnt) begin
            fifo_d[tail_q] = {gnt_wr, sel_id, out_of_range};
        end
        tail_d = tail_q + PtrW'(gnt);
        head_d = head_q + PtrW'(pop);
        cnt_d  = cnt_q + CntW'(gnt) - CntW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q      <= 1'b0;
            tc_valid_q <= 1'b0;
            tc_addr_q  <= '0;
            tc_bit_q   <= '0;
            tc_we_q    <= 1'b0;
            tc_wtag_q  <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
        end else begin
            ptr_q      <= ptr_d;
            tc_valid_q <= tc_valid_d;
            tc_addr_q  <= tc_addr_d;
            tc_bit_q   <= tc_bit_d;
            tc_we_q    <= tc_we_d;
            tc_wtag_q  <= tc_wtag_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        fifo_q <= fifo_d;
    end

    assign rd_req_ready_o = gnt_rd;
    assign wr_req_ready_o = gnt_wr;
    assign tc_req_valid_o = tc_valid_q;
    assign tc_req_addr_o  = tc_addr_q;
    assign tc_req_bit_o   = tc_bit_q;
    assign tc_req_we_o    = tc_we_q;
    assign tc_req_wtag_o  = tc_wtag_q;
    assign tc_rsp_ready_o = tc_rsp_ready;
    assign rd_rsp_valid_o = rd_rsp_valid;
    assign rd_rsp_id_o    = rd_rsp_id;
    assign rd_rsp_tag_o   = rd_rsp_tag;
    assign rd_rsp_err_o   = rd_rsp_err;
    assign wr_rsp_valid_o = wr_rsp_valid;
    assign wr_rsp_id_o    = wr_rsp_id;
    assign wr_rsp_err_o   = wr_rsp_err;

    // A tag-cache response with nothing outstanding has no owner.
    rsp_without_request_a : assert property (
        @(posedge clk_i) disable iff (rst_i) !(tc_rsp_valid_i && fifo_empty));

endmodule

// File: tb/tb_axi_tagctrl_tag_arb.sv
// Directed bench for axi_tagctrl_tag_arb: address map, fairness, backpressure,
// out-of-range ordering, response routing and mid-operation reset.
module tb_axi_tagctrl_tag_arb;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        rd_req_valid_i, rd_req_ready_o;
    logic [63:0] rd_req_addr_i;
    logic [3:0]  rd_req_id_i;
    logic        wr_req_valid_i, wr_req_ready_o;
    logic [63:0] wr_req_addr_i;
    logic [3:0]  wr_req_id_i;
    logic        wr_req_tag_i;
    logic        tc_req_valid_o, tc_req_ready_i;
    logic [63:0] tc_req_addr_o;
    logic [2:0]  tc_req_bit_o;
    logic        tc_req_we_o, tc_req_wtag_o;
    logic        tc_rsp_valid_i, tc_rsp_ready_o, tc_rsp_tag_i;
    logic        rd_rsp_valid_o, rd_rsp_ready_i;
    logic [3:0]  rd_rsp_id_o;
    logic        rd_rsp_tag_o, rd_rsp_err_o;
    logic        wr_rsp_valid_o, wr_rsp_ready_i;
    logic [3:0]  wr_rsp_id_o;
    logic        wr_rsp_err_o;

    int errors = 0;
    int checks = 0;

    axi_tagctrl_tag_arb dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rd_req_valid_i (rd_req_valid_i),
        .rd_req_ready_o (rd_req_ready_o),
        .rd_req_addr_i  (rd_req_addr_i),
        .rd_req_id_i    (rd_req_id_i),
        .wr_req_valid_i (wr_req_valid_i),
        .wr_req_ready_o (wr_req_ready_o),
        .wr_req_addr_i  (wr_req_addr_i),
        .wr_req_id_i    (wr_req_id_i),
        .wr_req_tag_i   (wr_req_tag_i),
        .tc_req_valid_o (tc_req_valid_o),
        .tc_req_ready_i (tc_req_ready_i),
        .tc_req_addr_o  (tc_req_addr_o),
        .tc_req_bit_o   (tc_req_bit_o),
        .tc_req_we_o    (tc_req_we_o),
        .tc_req_wtag_o  (tc_req_wtag_o),
        .tc_rsp_valid_i (tc_rsp_valid_i),
        .tc_rsp_ready_o (tc_rsp_ready_o),
        .tc_rsp_tag_i   (tc_rsp_tag_i),
        .rd_rsp_valid_o (rd_rsp_valid_o),
        .rd_rsp_ready_i (rd_rsp_ready_i),
        .rd_rsp_id_o    (rd_rsp_id_o),
        .rd_rsp_tag_o   (rd_rsp_tag_o),
        .rd_rsp_err_o   (rd_rsp_err_o),
        .wr_rsp_valid_o (wr_rsp_valid_o),
        .wr_rsp_ready_i (wr_rsp_ready_i),
        .wr_rsp_id_o    (wr_rsp_id_o),
        .wr_rsp_err_o   (wr_rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 2 units after the rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    task automatic issue(input logic is_wr, input logic [63:0] a, input logic [3:0] id,
                         input logic t);
        if (is_wr) begin
            wr_req_valid_i = 1'b1; wr_req_addr_i = a; wr_req_id_i = id; wr_req_tag_i = t;
        end else begin
            rd_req_valid_i = 1'b1; rd_req_addr_i = a; rd_req_id_i = id;
        end
        #1;
        chk("issue_grant", 64'(is_wr ? wr_req_ready_o : rd_req_ready_o), 64'd1);
        cyc();
        rd_req_valid_i = 1'b0;
        wr_req_valid_i = 1'b0;
    endtask

    task automatic exp_rsp(input string tag, input logic is_wr, input logic [3:0] id,
                           input logic t, input logic err);
        #1;
        chk({tag, "_rdv"}, 64'(rd_rsp_valid_o), 64'(!is_wr));
        chk({tag, "_wrv"}, 64'(wr_rsp_valid_o), 64'(is_wr));
        if (is_wr) begin
            chk({tag, "_wid"}, 64'(wr_rsp_id_o), 64'(id));
            chk({tag, "_werr"}, 64'(wr_rsp_err_o), 64'(err));
        end else begin
            chk({tag, "_rid"}, 64'(rd_rsp_id_o), 64'(id));
            chk({tag, "_rtag"}, 64'(rd_rsp_tag_o), 64'(t));
            chk({tag, "_rerr"}, 64'(rd_rsp_err_o), 64'(err));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1;
        rd_req_valid_i = 1'b1; rd_req_addr_i = 64'h8000_0000; rd_req_id_i = 4'd0;
        wr_req_valid_i = 1'b0; wr_req_addr_i = '0; wr_req_id_i = 4'd0; wr_req_tag_i = 1'b0;
        tc_req_ready_i = 1'b0;
        tc_rsp_valid_i = 1'b0; tc_rsp_tag_i = 1'b0;
        rd_rsp_ready_i = 1'b0; wr_rsp_ready_i = 1'b0;

        // Reset values, with a read request pending to prove reset blocks grants
        cyc(); cyc(); #1;
        chk("rst_tc_valid", 64'(tc_req_valid_o), 64'd0);
        chk("rst_rd_ready", 64'(rd_req_ready_o), 64'd0);
        chk("rst_wr_ready", 64'(wr_req_ready_o), 64'd0);
        chk("rst_rd_rsp_valid", 64'(rd_rsp_valid_o), 64'd0);
        chk("rst_wr_rsp_valid", 64'(wr_rsp_valid_o), 64'd0);
        chk("rst_tc_rsp_ready", 64'(tc_rsp_ready_o), 64'd0);
        chk("rst_tc_addr", tc_req_addr_o, 64'd0);
        chk("rst_tc_bit", 64'(tc_req_bit_o), 64'd0);
        chk("rst_tc_we", 64'(tc_req_we_o), 64'd0);
        rd_req_valid_i = 1'b0;
        rst_i = 1'b0;
        cyc();

        // Address map: 0x8000_0130 -> cap 0x13 -> byte 0xBE00_0002, bit 3
        tc_req_ready_i = 1'b1;
        rd_req_valid_i = 1'b1; rd_req_addr_i = 64'h8000_0130; rd_req_id_i = 4'd5;
        #1;
        chk("map_grant", 64'(rd_req_ready_o), 64'd1);
        chk("map_lat0", 64'(tc_req_valid_o), 64'd0);
        cyc();
        rd_req_valid_i = 1'b0;
        chk("map_valid", 64'(tc_req_valid_o), 64'd1);
        chk("map_addr", tc_req_addr_o, 64'hBE00_0002);
        chk("map_bit", 64'(tc_req_bit_o), 64'd3);
        chk("map_we", 64'(tc_req_we_o), 64'd0);
        cyc();
        chk("map_accepted", 64'(tc_req_valid_o), 64'd0);
        tc_rsp_valid_i = 1'b1; tc_rsp_tag_i = 1'b1; rd_rsp_ready_i = 1'b1;
        exp_rsp("map_rsp", 1'b0, 4'd5, 1'b1, 1'b0);
        chk("map_tc_rsp_ready", 64'(tc_rsp_ready_o), 64'd1);
        cyc();
        tc_rsp_valid_i = 1'b0;
        #1;
        chk("map_popped", 64'(rd_rsp_valid_o), 64'd0);

        // Fairness: both valid -> rd, wr, rd, wr, then full
        rd_req_valid_i = 1'b1; rd_req_addr_i = 64'h8000_0000; rd_req_id_i = 4'd1;
        wr_req_valid_i = 1'b1; wr_req_addr_i = 64'h8000_0010; wr_req_id_i = 4'd2;
        wr_req_tag_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fair_rd_ready", 64'(rd_req_ready_o), 64'(i % 2 == 0));
            chk("fair_wr_ready", 64'(wr_req_ready_o), 64'(i % 2 == 1));
            cyc();
            chk("fair_valid", 64'(tc_req_valid_o), 64'd1);
            chk("fair_addr", tc_req_addr_o, 64'hBE00_0000);
            chk("fair_bit", 64'(tc_req_bit_o), 64'(i % 2));
            chk("fair_we", 64'(tc_req_we_o), 64'(i % 2));
            chk("fair_wtag", 64'(tc_req_wtag_o), 64'(i % 2));
        end
        // Full with a pop in the same cycle: still no grant
        tc_rsp_valid_i = 1'b1; tc_rsp_tag_i = 1'b0; wr_rsp_ready_i = 1'b1;
        #1;
        chk("full_pop_rd_ready", 64'(rd_req_ready_o), 64'd0);
        chk("full_pop_wr_ready", 64'(wr_req_ready_o), 64'd0);
        exp_rsp("fair_rsp0", 1'b0, 4'd1, 1'b0, 1'b0);
        cyc();
        rd_req_valid_i = 1'b0; wr_req_valid_i = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tc_rsp_tag_i = (i == 2);
            exp_rsp("fair_rsp", (i % 2 == 1), (i % 2 == 1) ? 4'd2 : 4'd1, (i == 2), 1'b0);
            cyc();
        end
        tc_rsp_valid_i = 1'b0;

        // Backpressure: stage held, then FIFO fills to 4
        tc_req_ready_i = 1'b0;
        rd_req_valid_i = 1'b1; rd_req_addr_i = 64'h8000_0130; rd_req_id_i = 4'd3;
        #1;
        chk("bp_first_grant", 64'(rd_req_ready_o), 64'd1);
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_valid", 64'(tc_req_valid_o), 64'd1);
            chk("bp_hold_addr", tc_req_addr_o, 64'hBE00_0002);
            chk("bp_hold_bit", 64'(tc_req_bit_o), 64'd3);
            #1;
            chk("bp_no_grant", 64'(rd_req_ready_o), 64'd0);
            cyc();
        end
        tc_req_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_refill", 64'(rd_req_ready_o), 64'd1);
            cyc();
        end
        wr_req_valid_i = 1'b1; wr_req_addr_i = 64'h8000_0010; wr_req_id_i = 4'd8;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("bp_full_rd", 64'(rd_req_ready_o), 64'd0);
            chk("bp_full_wr", 64'(wr_req_ready_o), 64'd0);
            cyc();
        end
        rd_req_valid_i = 1'b0; wr_req_valid_i = 1'b0;
        tc_rsp_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tc_rsp_tag_i = k[0];
            exp_rsp("bp_rsp", 1'b0, 4'd3, k[0], 1'b0);
            cyc();
        end
        tc_rsp_valid_i = 1'b0;

        // Out of range write queued behind two in-range reads
        wr_rsp_ready_i = 1'b0;
        issue(1'b0, 64'h8000_0000, 4'd6, 1'b0);
        issue(1'b0, 64'h8000_0000, 4'd7, 1'b0);
        issue(1'b1, 64'h7FFF_FFF0, 4'd9, 1'b1);
        chk("oor_not_issued", 64'(tc_req_valid_o), 64'd0);
        chk("oor_wr_waits", 64'(wr_rsp_valid_o), 64'd0);
        tc_rsp_valid_i = 1'b1; tc_rsp_tag_i = 1'b0;
        exp_rsp("oor_rd6", 1'b0, 4'd6, 1'b0, 1'b0);
        cyc();
        tc_rsp_tag_i = 1'b1;
        exp_rsp("oor_rd7", 1'b0, 4'd7, 1'b1, 1'b0);
        cyc();
        tc_rsp_valid_i = 1'b0;
        exp_rsp("oor_wr_err", 1'b1, 4'd9, 1'b0, 1'b1);
        chk("oor_tc_rsp_ready", 64'(tc_rsp_ready_o), 64'd0);
        cyc();
        exp_rsp("oor_wr_held", 1'b1, 4'd9, 1'b0, 1'b1);
        wr_rsp_ready_i = 1'b1;
        cyc();
        #1;
        chk("oor_wr_popped", 64'(wr_rsp_valid_o), 64'd0);
        // Upper bound is exclusive; last capability below it is issued
        issue(1'b0, 64'hC000_0000, 4'd4, 1'b0);
        chk("hi_not_issued", 64'(tc_req_valid_o), 64'd0);
        exp_rsp("hi_err", 1'b0, 4'd4, 1'b0, 1'b1);
        cyc();
        issue(1'b0, 64'hBFFF_FFF0, 4'd10, 1'b0);
        chk("top_valid", 64'(tc_req_valid_o), 64'd1);
        chk("top_addr", tc_req_addr_o, 64'hBE7F_FFFF);
        chk("top_bit", 64'(tc_req_bit_o), 64'd7);
        cyc();
        tc_rsp_valid_i = 1'b1; tc_rsp_tag_i = 1'b1;
        exp_rsp("top_rsp", 1'b0, 4'd10, 1'b1, 1'b0);
        cyc();
        tc_rsp_valid_i = 1'b0;

        // Response ordering with the read-response side stalled
        issue(1'b0, 64'h8000_0000, 4'd1, 1'b0);
        issue(1'b1, 64'h8000_0010, 4'd2, 1'b0);
        issue(1'b0, 64'h8000_0020, 4'd3, 1'b0);
        issue(1'b1, 64'h8000_0030, 4'd4, 1'b1);
        rd_rsp_ready_i = 1'b0;
        tc_rsp_valid_i = 1'b1; tc_rsp_tag_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_rsp("ord_stall", 1'b0, 4'd1, 1'b1, 1'b0);
            chk("ord_stall_ready", 64'(tc_rsp_ready_o), 64'd0);
            cyc();
        end
        rd_rsp_ready_i = 1'b1;
        #1;
        chk("ord_release", 64'(tc_rsp_ready_o), 64'd1);
        cyc();
        exp_rsp("ord_wr2", 1'b1, 4'd2, 1'b0, 1'b0);
        cyc();
        tc_rsp_tag_i = 1'b0;
        exp_rsp("ord_rd3", 1'b0, 4'd3, 1'b0, 1'b0);
        cyc();
        exp_rsp("ord_wr4", 1'b1, 4'd4, 1'b0, 1'b0);
        cyc();
        tc_rsp_valid_i = 1'b0;

        // Reset with 3 outstanding and the pointer favouring writes
        rd_req_valid_i = 1'b1; rd_req_addr_i = 64'h8000_0000; rd_req_id_i = 4'd1;
        wr_req_valid_i = 1'b1; wr_req_addr_i = 64'h8000_0010; wr_req_id_i = 4'd2;
        #1;
        chk("pre_rst_rd", 64'(rd_req_ready_o), 64'd1);
        cyc();
        rd_req_valid_i = 1'b0;
        issue(1'b1, 64'h8000_0010, 4'd2, 1'b0);
        issue(1'b0, 64'h8000_0000, 4'd1, 1'b0);
        tc_req_ready_i = 1'b0;
        rst_i = 1'b1;
        rd_req_valid_i = 1'b1; wr_req_valid_i = 1'b1;
        #1;
        chk("in_rst_rd_ready", 64'(rd_req_ready_o), 64'd0);
        chk("in_rst_wr_ready", 64'(wr_req_ready_o), 64'd0);
        cyc();
        rst_i = 1'b0;
        chk("post_rst_tc_valid", 64'(tc_req_valid_o), 64'd0);
        chk("post_rst_rd_rsp", 64'(rd_rsp_valid_o), 64'd0);
        chk("post_rst_wr_rsp", 64'(wr_rsp_valid_o), 64'd0);
        chk("post_rst_empty", 64'(tc_rsp_ready_o), 64'd0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("post_rst_rd_gnt", 64'(rd_req_ready_o), 64'(k % 2 == 0));
            chk("post_rst_wr_gnt", 64'(wr_req_ready_o), 64'(k % 2 == 1));
            tc_req_ready_i = 1'b1;
            cyc();
        end
        #1;
        chk("post_rst_full_rd", 64'(rd_req_ready_o), 64'd0);
        chk("post_rst_full_wr", 64'(wr_req_ready_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
